// File: rtl/network_wb_out_pkg.sv
// Shared definitions for the butterfly write-back path: mode encodings,
// write-back FSM states and the default pipeline latencies.
package network_wb_out_pkg;

  // Operation modes that need special latency handling
  localparam logic [2:0] MODE_COPY = 3'b000;
  localparam logic [2:0] MODE_PWM  = 3'b010;

  // Default butterfly pipeline latencies, shared with network_bf_out
  localparam int LAT_SHORT = 7;
  localparam int LAT_LONG  = 10;

  // Write-back controller states
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } wb_state_e;

  // Butterfly latency for a given mode: copy bypasses the pipeline,
  // pointwise multiply takes the long path, everything else the short one.
  function automatic int wb_latency(input logic [2:0] mode,
                                    input int lat_short,
                                    input int lat_long);
    if (mode == MODE_COPY) begin
      return 0;
    end else if (mode == MODE_PWM) begin
      return lat_long;
    end else begin
      return lat_short;
    end
  endfunction

endpackage

// File: rtl/network_wb_out_delay.sv
// Fixed-depth shift register with a runtime-selectable tap. Tap 0 is the
// live input; tap k is the input delayed by k cycles.
module wb_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic [SEL_W-1:0] tap_sel,
  output logic [WIDTH-1:0] tap_out,
  output logic [DEPTH-1:0] stage_msb
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Shift by one stage per cycle; flush empties the whole line at once
  always_comb begin
    stage_d[0] = flush ? '0 : din;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = flush ? '0 : stage_q[k-1];
    end
  end

  // Stage registers, cleared on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // Tap mux: select 0 bypasses the register chain
  always_comb begin
    tap_out = din;
    for (int k = 0; k < DEPTH; k++) begin
      if (tap_sel == SEL_W'(k + 1)) begin
        tap_out = stage_q[k];
      end
    end
  end

  // Top bit of every stage, used by the owner as an occupancy flag
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_msb[k] = stage_q[k][WIDTH-1];
    end
  end

endmodule

// File: rtl/network_wb_out.sv
// Write-back stage behind the butterfly output router. Delays the read-side
// addresses and lane enables to line up with the routed data, commits the
// four lanes to the coefficient banks and reports when an operation drains.
module network_wb_out
  import network_wb_out_pkg::*;
#(
  parameter int data_width = 23,
  parameter int addr_width = 6,
  parameter int lat_short  = LAT_SHORT,
  parameter int lat_long   = LAT_LONG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            sel,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [3:0]            lane_en,
  input  logic [addr_width-1:0] rd_addr_0,
  input  logic [addr_width-1:0] rd_addr_1,
  input  logic [addr_width-1:0] rd_addr_2,
  input  logic [addr_width-1:0] rd_addr_3,
  input  logic [data_width-1:0] d0,
  input  logic [data_width-1:0] d1,
  input  logic [data_width-1:0] d2,
  input  logic [data_width-1:0] d3,
  output logic                  wr_en_0,
  output logic                  wr_en_1,
  output logic                  wr_en_2,
  output logic                  wr_en_3,
  output logic [addr_width-1:0] wr_addr_0,
  output logic [addr_width-1:0] wr_addr_1,
  output logic [addr_width-1:0] wr_addr_2,
  output logic [addr_width-1:0] wr_addr_3,
  output logic [data_width-1:0] wr_data_0,
  output logic [data_width-1:0] wr_data_1,
  output logic [data_width-1:0] wr_data_2,
  output logic [data_width-1:0] wr_data_3,
  output logic                  busy,
  output logic                  done
);

  localparam int BUNDLE_W = 1 + 4 + 4 * addr_width;
  localparam int TAP_W    = $clog2(lat_long + 1);
  localparam int PEND_W   = $clog2(lat_long + 2);

  wb_state_e             state_q, state_d;
  logic [2:0]            mode_q, mode_d;
  logic [PEND_W-1:0]     pending_q, pending_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [3:0]            wr_en_q, wr_en_d;
  logic [addr_width-1:0] wr_addr_q [4];
  logic [addr_width-1:0] wr_addr_d [4];
  logic [data_width-1:0] wr_data_q [4];
  logic [data_width-1:0] wr_data_d [4];

  logic [data_width-1:0] d_lane [4];
  logic [addr_width-1:0] tap_addr [4];
  logic [BUNDLE_W-1:0]   bundle_in;
  logic [BUNDLE_W-1:0]   tap_bundle;
  logic [lat_long-1:0]   stage_occ;
  logic [TAP_W-1:0]      tap_sel;
  logic                  tap_valid;
  logic [3:0]            tap_lane_en;
  logic                  accept_start;
  logic                  accept_valid;
  logic                  in_flight;
  logic                  drain_clear;
  logic                  done_int;

  assign d_lane[0] = d0;
  assign d_lane[1] = d1;
  assign d_lane[2] = d2;
  assign d_lane[3] = d3;

  // A start is only taken from IDLE, and reads only count while running
  assign accept_start = (state_q == IDLE) && start;
  assign accept_valid = (state_q == RUN) && in_valid;

  assign bundle_in = {accept_valid, lane_en, rd_addr_3, rd_addr_2, rd_addr_1, rd_addr_0};

  // Tap position follows the frozen mode of the current operation
  always_comb begin
    tap_sel = TAP_W'(wb_latency(mode_q, lat_short, lat_long));
  end

  wb_delay_line #(
    .WIDTH (BUNDLE_W),
    .DEPTH (lat_long),
    .SEL_W (TAP_W)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (accept_start),
    .din       (bundle_in),
    .tap_sel   (tap_sel),
    .tap_out   (tap_bundle),
    .stage_msb (stage_occ)
  );

  // Unpack the tapped bundle into valid, lane enables and lane addresses
  always_comb begin
    tap_valid   = tap_bundle[BUNDLE_W-1];
    tap_lane_en = tap_bundle[BUNDLE_W-2 -: 4];
    for (int i = 0; i < 4; i++) begin
      tap_addr[i] = tap_bundle[i*addr_width +: addr_width];
    end
  end

  // Any valid entry still ahead of the tap means writes are outstanding
  always_comb begin
    in_flight = 1'b0;
    for (int k = 0; k < lat_long; k++) begin
      if ((TAP_W'(k) < tap_sel) && stage_occ[k]) begin
        in_flight = 1'b1;
      end
    end
  end

  assign drain_clear = (pending_q == '0) && !in_flight;

  // Controller next state: accept start, run until the last read, then drain
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    done_int = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = sel;
        end
      end
      RUN: begin
        if (in_valid && in_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_clear) begin
          state_d  = IDLE;
          done_int = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding-entry count: up on accepted reads, down once a write retires
  always_comb begin
    pending_d = pending_q;
    if (accept_valid && !wr_valid_q) begin
      pending_d = pending_q + PEND_W'(1);
    end else if (!accept_valid && wr_valid_q && (pending_q != '0)) begin
      pending_d = pending_q - PEND_W'(1);
    end
    if (accept_start) begin
      pending_d = '0;
    end
  end

  // Bank write register inputs; address and data hold while a lane is idle
  always_comb begin
    wr_valid_d = tap_valid;
    for (int i = 0; i < 4; i++) begin
      wr_en_d[i]   = tap_valid & tap_lane_en[i];
      wr_addr_d[i] = wr_en_d[i] ? tap_addr[i] : wr_addr_q[i];
      wr_data_d[i] = wr_en_d[i] ? d_lane[i]   : wr_data_q[i];
    end
  end

  // All state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE_COPY;
      pending_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_en_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        wr_addr_q[i] <= '0;
        wr_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pending_q  <= pending_d;
      wr_valid_q <= wr_valid_d;
      wr_en_q    <= wr_en_d;
      for (int i = 0; i < 4; i++) begin
        wr_addr_q[i] <= wr_addr_d[i];
        wr_data_q[i] <= wr_data_d[i];
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_int;

  assign wr_en_0   = wr_en_q[0];
  assign wr_en_1   = wr_en_q[1];
  assign wr_en_2   = wr_en_q[2];
  assign wr_en_3   = wr_en_q[3];
  assign wr_addr_0 = wr_addr_q[0];
  assign wr_addr_1 = wr_addr_q[1];
  assign wr_addr_2 = wr_addr_q[2];
  assign wr_addr_3 = wr_addr_q[3];
  assign wr_data_0 = wr_data_q[0];
  assign wr_data_1 = wr_data_q[1];
  assign wr_data_2 = wr_data_q[2];
  assign wr_data_3 = wr_data_q[3];

endmodule

// File: tb/tb_network_wb_out.sv
// Scoreboard bench for network_wb_out: each accepted read pushes its
// expected bank writes; a monitor pops and compares every write seen.
module tb_network_wb_out;

  typedef struct {
    int         lane;
    logic [5:0] addr;
    logic [22:0] data;
    int         cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  sel;
  logic        start;
  logic        in_valid;
  logic        in_last;
  logic [3:0]  lane_en;
  logic [5:0]  rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3;
  logic [22:0] d0, d1, d2, d3;
  logic        wr_en_0, wr_en_1, wr_en_2, wr_en_3;
  logic [5:0]  wr_addr_0, wr_addr_1, wr_addr_2, wr_addr_3;
  logic [22:0] wr_data_0, wr_data_1, wr_data_2, wr_data_3;
  logic        busy;
  logic        done;

  int   cyc;
  int   checks;
  int   errors;
  int   done_count;
  exp_t sb[$];
  exp_t mon_e;

  logic [3:0]  wr_en_v;
  logic [5:0]  wr_addr_v [4];
  logic [22:0] wr_data_v [4];

  network_wb_out dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .start     (start),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .lane_en   (lane_en),
    .rd_addr_0 (rd_addr_0),
    .rd_addr_1 (rd_addr_1),
    .rd_addr_2 (rd_addr_2),
    .rd_addr_3 (rd_addr_3),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .wr_en_0   (wr_en_0),
    .wr_en_1   (wr_en_1),
    .wr_en_2   (wr_en_2),
    .wr_en_3   (wr_en_3),
    .wr_addr_0 (wr_addr_0),
    .wr_addr_1 (wr_addr_1),
    .wr_addr_2 (wr_addr_2),
    .wr_addr_3 (wr_addr_3),
    .wr_data_0 (wr_data_0),
    .wr_data_1 (wr_data_1),
    .wr_data_2 (wr_data_2),
    .wr_data_3 (wr_data_3),
    .busy      (busy),
    .done      (done)
  );

  // Router model: lane data is a distinct function of cycle and lane so a
  // write taken from the wrong cycle shows up as a data error
  function automatic logic [22:0] dval(input int c, input int lane);
    return 23'(c * 8 + lane) ^ 23'h5A5A5;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: cycle n is the interval after the n-th rising edge
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign d0 = dval(cyc, 0);
  assign d1 = dval(cyc, 1);
  assign d2 = dval(cyc, 2);
  assign d3 = dval(cyc, 3);

  assign wr_en_v      = {wr_en_3, wr_en_2, wr_en_1, wr_en_0};
  assign wr_addr_v[0] = wr_addr_0;
  assign wr_addr_v[1] = wr_addr_1;
  assign wr_addr_v[2] = wr_addr_2;
  assign wr_addr_v[3] = wr_addr_3;
  assign wr_data_v[0] = wr_data_0;
  assign wr_data_v[1] = wr_data_1;
  assign wr_data_v[2] = wr_data_2;
  assign wr_data_v[3] = wr_data_3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every bank write must match the oldest outstanding expectation
  task automatic monitorLoop();
    forever begin
      @(negedge clk);
      if (done) done_count++;
      for (int i = 0; i < 4; i++) begin
        if (wr_en_v[i]) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_write: lane %0d addr %0h data %0h at cycle %0d, none expected",
                     i, wr_addr_v[i], wr_data_v[i], cyc);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.lane != i || mon_e.addr !== wr_addr_v[i] ||
                mon_e.data !== wr_data_v[i] || mon_e.cyc != cyc) begin
              errors++;
              $display("[TB] FAIL write: got lane %0d addr %0h data %0h cycle %0d, expected lane %0d addr %0h data %0h cycle %0d",
                       i, wr_addr_v[i], wr_data_v[i], cyc,
                       mon_e.lane, mon_e.addr, mon_e.data, mon_e.cyc);
            end
          end
        end
      end
    end
  endtask

  // Issue one read; when accepted, queue the writes expected lat+1 cycles on
  task automatic applyStimulus(input logic accept, input logic last,
                               input logic [3:0] en,
                               input logic [5:0] a0, input logic [5:0] a1,
                               input logic [5:0] a2, input logic [5:0] a3,
                               input int lat);
    logic [5:0] a [4];
    exp_t e;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    in_valid  = 1'b1;
    in_last   = last;
    lane_en   = en;
    rd_addr_0 = a0;
    rd_addr_1 = a1;
    rd_addr_2 = a2;
    rd_addr_3 = a3;
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (en[i]) begin
          e.lane = i;
          e.addr = a[i];
          e.data = dval(cyc + lat, i);
          e.cyc  = cyc + lat + 1;
          sb.push_back(e);
        end
      end
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic doStart(input logic [2:0] mode);
    start = 1'b1;
    sel   = mode;
    tick();
    start = 1'b0;
  endtask

  // Called right after the last read: done must pulse lat+1 cycles later,
  // and a start presented in that very cycle must be ignored
  task automatic finishOp(input string name, input int lat, input int done_before);
    repeat (lat + 1) tick();
    checkOutput({name, "_done_pulse"}, {31'd0, done}, 32'd1);
    checkOutput({name, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    start = 1'b1;
    sel   = 3'b001;
    tick();
    start = 1'b0;
    checkOutput({name, "_busy_after_done"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_done_cleared"}, {31'd0, done}, 32'd0);
    tick();
    checkOutput({name, "_done_count"}, done_count - done_before, 32'd1);
  endtask

  initial begin
    int dc;
    checks     = 0;
    errors     = 0;
    done_count = 0;
    rst_n      = 1'b0;
    sel        = 3'b000;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    lane_en    = 4'h0;
    rd_addr_0  = '0;
    rd_addr_1  = '0;
    rd_addr_2  = '0;
    rd_addr_3  = '0;
    fork
      monitorLoop();
    join_none
    tick();
    tick();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_wr_en", {28'd0, wr_en_v}, 32'd0);
    checkOutput("reset_wr_addr_2", {26'd0, wr_addr_2}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] copy mode");
    dc = done_count;
    doStart(3'b000);
    checkOutput("copy_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, (k == 3), 4'hF, 6'(4*k), 6'(4*k+1), 6'(4*k+2), 6'(4*k+3), 0);
    end
    finishOp("copy", 0, dc);

    $display("[TB] ntt mode");
    dc = done_count;
    doStart(3'b001);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, (k == 15), 4'hF, 6'(k), 6'(k+16), 6'(k+32), 6'(k+48), 7);
    end
    finishOp("ntt", 7, dc);

    $display("[TB] pwm mode");
    dc = done_count;
    doStart(3'b010);
    applyStimulus(1'b1, 1'b1, 4'b0100, 6'h11, 6'h22, 6'h2A, 6'h33, 10);
    finishOp("pwm", 10, dc);

    $display("[TB] mode hold");
    dc = done_count;
    doStart(3'b001);
    applyStimulus(1'b1, 1'b0, 4'b1001, 6'h05, 6'h06, 6'h07, 6'h08, 7);
    sel = 3'b010;
    applyStimulus(1'b1, 1'b0, 4'b0110, 6'h15, 6'h16, 6'h17, 6'h18, 7);
    sel = 3'b000;
    applyStimulus(1'b1, 1'b1, 4'b1111, 6'h25, 6'h26, 6'h27, 6'h28, 7);
    finishOp("hold", 7, dc);

    $display("[TB] ignored inputs");
    dc = done_count;
    applyStimulus(1'b0, 1'b0, 4'hF, 6'h01, 6'h02, 6'h03, 6'h04, 0);
    applyStimulus(1'b0, 1'b1, 4'hF, 6'h01, 6'h02, 6'h03, 6'h04, 0);
    checkOutput("idle_read_busy", {31'd0, busy}, 32'd0);
    start = 1'b1;
    sel   = 3'b001;
    applyStimulus(1'b0, 1'b0, 4'hF, 6'h3C, 6'h3D, 6'h3E, 6'h3F, 7);
    start = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'b0011, 6'h09, 6'h0A, 6'h0B, 6'h0C, 7);
    start = 1'b1;
    sel   = 3'b000;
    applyStimulus(1'b1, 1'b0, 4'b1100, 6'h19, 6'h1A, 6'h1B, 6'h1C, 7);
    start = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'b0000, 6'h29, 6'h2A, 6'h2B, 6'h2C, 7);
    finishOp("ignore", 7, dc);

    $display("[TB] reset mid-operation");
    dc = done_count;
    doStart(3'b001);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 4'hF, 6'(k), 6'(k), 6'(k), 6'(k), 7);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid_wr_en", {28'd0, wr_en_v}, 32'd0);
    repeat (14) tick();
    checkOutput("rst_mid_no_done", done_count - dc, 32'd0);
    checkOutput("rst_mid_busy_later", {31'd0, busy}, 32'd0);
    dc = done_count;
    doStart(3'b000);
    applyStimulus(1'b1, 1'b0, 4'b1010, 6'h31, 6'h32, 6'h33, 6'h34, 0);
    applyStimulus(1'b1, 1'b1, 4'b0101, 6'h35, 6'h36, 6'h37, 6'h38, 0);
    finishOp("after_rst", 0, dc);

    repeat (12) tick();
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
